cga_mac_ptlook: RTL and testbench
=================================

// Module: cga_mac_ptlook
// PURPOSE
//  Page-table lookup and permit-check stage of the CGA MAC. Sits directly downstream of the segment/PCR/XPT register stage.
//  Consumes PCR, PEX and XPT, which select the page table and supply the current ring.
//  For each logical access it reads one entry from page-table RAM over a req/ack handshake.
//  It checks permit and ring bits, then returns the physical page number (PPN) or a fault code to the MAC sequencer.
// PARAMETERS
//  PG_W     6   logical page-index width (VA bits 15:10)
//  PPN_W    9   physical page number width
//  TMO_CYC  15  maximum MCLK cycles PTRD may wait for PTACK before a timeout fault; 4-bit counter
// PORTS
//  MCLK          in   1      clock; all state changes on rising edge
//  RESETN        in   1      asynchronous, active-low reset
//  REQ           in   1      start translation; sampled only in IDLE
//  VA_15_10      in   PG_W   logical page index
//  WR            in   1      access is a write
//  FETCH         in   1      access is an instruction fetch (WR=0 assumed when set)
//  PCR_15_7_2_0  in   16     PCR from SEGPT stage; [8:7]=PT select, [1:0]=current ring
//  PEX           in   1      alternative page table enable (from SEGPT stage)
//  XPT_1_0       in   2      alternative page table number (from SEGPT stage)
//  INVAL         in   1      PCR/EXM reload strobe; invalidates cached translation
//  PTRD          out  1      page-table RAM read request
//  PTADR         out  2+PG_W {pt[1:0], page[5:0]}
//  PTACK         in   1      RAM data valid
//  PTDATA        in   16     entry: 15 WPM, 14 RPM, 13 FPM, 12 WIP, 11 PGU, 10:9 ring, 8:0 PPN
//  BUSY          out  1      high in every state except IDLE
//  DONE          out  1      one-cycle completion pulse
//  FAULT         out  1      valid with DONE
//  FCODE         out  3      valid with DONE; 0 = none
//  PPN           out  PPN_W  valid with DONE when FAULT=0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; timeout counter 0; cache invalid.
//  States: IDLE, LOOK, CHECK, RESP (one-hot or binary; encoding in package).
//  IDLE, REQ=1 -> LOOK. At the edge that takes it to LOOK, the block latches:
//   - VA, WR and FETCH;
//   - pt = PEX ? XPT_1_0 : PCR[8:7];
//   - ring = PCR[1:0].
//   Later PCR/PEX/XPT changes do not affect the translation in flight.
//  LOOK: PTRD=1 and PTADR holds steady.
//   - PTACK=1 -> CHECK; PTDATA is registered and PTRD drops on the same edge.
//   - Counter reaches TMO_CYC without PTACK -> RESP with FCODE=6.
//  CHECK -> RESP. Fault priority, highest first:
//   1 WPM=RPM=FPM=0 (page not present)
//   2 ring < entry ring
//   3 WR & !WPM
//   4 FETCH & !FPM
//   5 read (!WR & !FETCH) & !RPM
//  RESP: DONE=1 for exactly one cycle, with FAULT/FCODE/PPN valid -> IDLE.
//   PPN is forced to 0 when FAULT=1.
//   DONE, FAULT, FCODE and PPN are registered outputs.
//  Latency: REQ edge e0; PTACK sampled high at e1; DONE high between e3 and e4. Minimum is 3 cycles.
//  REQ while BUSY is ignored; it is not queued.
//  A REQ held high across RESP starts a new lookup on the edge after DONE.
//  PTACK outside LOOK is ignored.
//  INVAL during LOOK/CHECK does not abort the translation in flight.
//  RESETN low mid-operation: PTRD, DONE and BUSY fall immediately (asynchronously); the request is lost.
//  Timeout counter clears on entry to LOOK and saturates; it never wraps.
// CONFIGURATION
//  CGA_MAC_PTCACHE_EN defined:
//   - Adds a one-entry cache holding {pt, page, entry} of the last non-faulting lookup.
//   - REQ in IDLE matching pt and page goes IDLE -> CHECK, skipping LOOK and PTRD. DONE arrives at e2.
//   - Permit and ring checks still run against the current WR/FETCH/ring.
//   - INVAL or reset clears the valid bit. INVAL on the same edge as a hit REQ wins, so the access misses.
//  Not defined: no cache; every REQ performs LOOK.
// STRUCTURE
//  Package cga_mac_pkg holds:
//   - state enum;
//   - FCODE constants (FC_NONE=0 .. FC_TMO=6);
//   - PTDATA field positions (WPM_B, RPM_B, FPM_B, RING_MSB/LSB, PPN_MSB/LSB).
//  Sub-module cga_mac_ptlook_chk: purely combinational fault-priority encoder.
//   Inputs: registered entry, ring, WR, FETCH. Outputs: fault, fcode.
//  The FSM, counter and optional cache stay in the top module.
// TESTING
//  1. Read hit: PEX=0, PCR[8:7]=2, VA page 0x05, PTACK at e1, PTDATA=0x4123 (RPM, ring 0, PPN 0x123)
//     -> PTADR=0x85, DONE at e3, FAULT=0, PPN=0x123.
//  2. PEX=1, XPT=3, write, PTDATA with WPM=0 and RPM=1 -> PTADR[7:6]=3, FAULT=1, FCODE=3.
//  3. Ring: PCR[1:0]=1, entry ring=2, all permits set -> FCODE=2. The same access with PTDATA=0x0000 -> FCODE=1 (priority).
//  4. PTACK never asserted -> PTRD high for 15 cycles, then DONE with FCODE=6 and PPN=0.
//  5. RESETN pulsed low while in LOOK -> PTRD=0 and BUSY=0 immediately. A later REQ completes normally.
//  6. CGA_MAC_PTCACHE_EN: repeat test 1 -> no PTRD, DONE at e2.
//     INVAL, then repeat -> PTRD issued again.

Source files
------------

// File: rtl/cga_mac_pkg.sv
// Shared definitions for the CGA MAC page-table lookup stage.
//   state_t    : lookup FSM states
//   FC_*       : fault codes reported on FCODE (0 = no fault)
//   *_B/*_MSB/*_LSB : field positions inside a 16-bit page-table entry
package cga_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOOK  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_NP    = 3'd1;  // page not present
  localparam logic [2:0] FC_RING  = 3'd2;  // ring violation
  localparam logic [2:0] FC_WR    = 3'd3;  // write not permitted
  localparam logic [2:0] FC_FETCH = 3'd4;  // fetch not permitted
  localparam logic [2:0] FC_RD    = 3'd5;  // read not permitted
  localparam logic [2:0] FC_TMO   = 3'd6;  // page-table RAM timeout

  localparam int WPM_B    = 15;
  localparam int RPM_B    = 14;
  localparam int FPM_B    = 13;
  localparam int RING_MSB = 10;
  localparam int RING_LSB = 9;
  localparam int PPN_MSB  = 8;
  localparam int PPN_LSB  = 0;

endpackage

// File: rtl/cga_mac_ptlook_chk.sv
// Combinational permit/ring fault-priority encoder.
// Ports:
//   entry : registered page-table entry (16 bits)
//   ring  : current ring of the access
//   wr    : access is a write
//   fetch : access is an instruction fetch
//   fault : any fault detected
//   fcode : highest-priority fault code (FC_NONE when clean)
module cga_mac_ptlook_chk
  import cga_mac_pkg::*;
(
  input  logic [15:0] entry,
  input  logic [1:0]  ring,
  input  logic        wr,
  input  logic        fetch,
  output logic        fault,
  output logic [2:0]  fcode
);

  // WIP and PGU are carried in the entry but not checked here.
  logic unused_bits;
  assign unused_bits = ^entry[12:11];

  always_comb begin
    fcode = FC_NONE;
    if (!entry[WPM_B] && !entry[RPM_B] && !entry[FPM_B])
      fcode = FC_NP;
    else if (ring < entry[RING_MSB:RING_LSB])
      fcode = FC_RING;
    else if (wr && !entry[WPM_B])
      fcode = FC_WR;
    else if (fetch && !entry[FPM_B])
      fcode = FC_FETCH;
    else if (!wr && !fetch && !entry[RPM_B])
      fcode = FC_RD;
    fault = (fcode != FC_NONE);
  end

endmodule

// File: rtl/cga_mac_ptlook.sv
// CGA MAC page-table lookup and permit-check stage.
// Reads one page-table entry per access over a PTRD/PTACK handshake, checks
// permit and ring bits, and returns PPN or a fault code with a DONE pulse.
// Optional feature macro: CGA_MAC_PTCACHE_EN (one-entry translation cache).
// Ports:
//   MCLK, RESETN            clock, asynchronous active-low reset
//   REQ, VA_15_10, WR, FETCH access request (REQ sampled only in IDLE)
//   PCR_15_7_2_0, PEX, XPT_1_0  page-table select and current ring
//   INVAL                   invalidates the cached translation
//   PTRD, PTADR             page-table RAM read request / address {pt, page}
//   PTACK, PTDATA           RAM data valid / entry
//   BUSY                    high whenever the FSM is not IDLE
//   DONE, FAULT, FCODE, PPN registered result, valid with the DONE pulse
// Handshake: PTRD stays high with PTADR steady until PTACK is sampled high on
// a rising edge; the entry is captured on that edge and PTRD drops with it.
module cga_mac_ptlook
  import cga_mac_pkg::*;
#(
  parameter int PG_W    = 6,
  parameter int PPN_W   = 9,
  parameter int TMO_CYC = 15
) (
  input  logic              MCLK,
  input  logic              RESETN,
  input  logic              REQ,
  input  logic [PG_W-1:0]   VA_15_10,
  input  logic              WR,
  input  logic              FETCH,
  input  logic [15:0]       PCR_15_7_2_0,
  input  logic              PEX,
  input  logic [1:0]        XPT_1_0,
  input  logic              INVAL,
  output logic              PTRD,
  output logic [2+PG_W-1:0] PTADR,
  input  logic              PTACK,
  input  logic [15:0]       PTDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAULT,
  output logic [2:0]        FCODE,
  output logic [PPN_W-1:0]  PPN
);

  state_t            state_q, state_d;
  logic [PG_W-1:0]   va_q;
  logic              wr_q, fetch_q;
  logic [1:0]        pt_q, ring_q;
  logic [15:0]       entry_q;
  logic [3:0]        tmo_cnt, cnt_inc;
  logic              fault_q;
  logic [2:0]        fcode_q;
  logic              timeout;
  logic              hit;
  logic [15:0]       cache_entry;
  logic [1:0]        pt_sel;
  logic              chk_fault;
  logic [2:0]        chk_fcode;

  logic unused_pcr;
  assign unused_pcr = ^{PCR_15_7_2_0[15:9], PCR_15_7_2_0[6:2]};

  assign pt_sel  = PEX ? XPT_1_0 : PCR_15_7_2_0[8:7];
  // Saturating increment: the counter must never wrap back to zero.
  assign cnt_inc = (tmo_cnt == 4'hF) ? tmo_cnt : tmo_cnt + 4'd1;

`ifdef CGA_MAC_PTCACHE_EN
  logic            c_valid;
  logic [1:0]      c_pt;
  logic [PG_W-1:0] c_page;
  logic [15:0]     c_entry;

  // INVAL on the same edge as a REQ forces a miss.
  assign hit         = c_valid && !INVAL && (c_pt == pt_sel) && (c_page == VA_15_10);
  assign cache_entry = c_entry;

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      c_valid <= 1'b0;
      c_pt    <= '0;
      c_page  <= '0;
      c_entry <= '0;
    end else if (INVAL) begin
      c_valid <= 1'b0;
    end else if (state_q == ST_CHECK && !chk_fault) begin
      c_valid <= 1'b1;
      c_pt    <= pt_q;
      c_page  <= va_q;
      c_entry <= entry_q;
    end
  end
`else
  logic unused_inval;
  assign unused_inval = INVAL;
  assign hit          = 1'b0;
  assign cache_entry  = 16'h0000;
`endif

  cga_mac_ptlook_chk u_chk (
    .entry (entry_q),
    .ring  (ring_q),
    .wr    (wr_q),
    .fetch (fetch_q),
    .fault (chk_fault),
    .fcode (chk_fcode)
  );

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE:  if (REQ) state_d = hit ? ST_CHECK : ST_LOOK;
      ST_LOOK: begin
        if (PTACK) begin
          state_d = ST_CHECK;
        end else if (cnt_inc == 4'(TMO_CYC)) begin
          state_d = ST_RESP;
          timeout = 1'b1;
        end
      end
      ST_CHECK: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      va_q    <= '0;
      wr_q    <= 1'b0;
      fetch_q <= 1'b0;
      pt_q    <= '0;
      ring_q  <= '0;
      entry_q <= '0;
      tmo_cnt <= '0;
      fault_q <= 1'b0;
      fcode_q <= FC_NONE;
      DONE    <= 1'b0;
      FAULT   <= 1'b0;
      FCODE   <= FC_NONE;
      PPN     <= '0;
    end else begin
      DONE <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (REQ) begin
            va_q    <= VA_15_10;
            wr_q    <= WR;
            fetch_q <= FETCH;
            pt_q    <= pt_sel;
            ring_q  <= PCR_15_7_2_0[1:0];
            tmo_cnt <= '0;
            if (hit) entry_q <= cache_entry;
          end
        end
        ST_LOOK: begin
          if (PTACK) begin
            entry_q <= PTDATA;
          end else begin
            tmo_cnt <= cnt_inc;
            if (timeout) begin
              fault_q <= 1'b1;
              fcode_q <= FC_TMO;
            end
          end
        end
        ST_CHECK: begin
          fault_q <= chk_fault;
          fcode_q <= chk_fcode;
        end
        ST_RESP: begin
          DONE  <= 1'b1;
          FAULT <= fault_q;
          FCODE <= fcode_q;
          PPN   <= fault_q ? '0 : PPN_W'(entry_q[PPN_MSB:PPN_LSB]);
        end
        default: ;
      endcase
    end
  end

  assign PTRD  = (state_q == ST_LOOK);
  assign BUSY  = (state_q != ST_IDLE);
  assign PTADR = {pt_q, va_q};

endmodule

// File: tb/tb_cga_mac_ptlook.sv
// Directed bench for cga_mac_ptlook. Expected results are pushed to exp_q
// when a request is issued and popped when DONE is seen.
module tb_cga_mac_ptlook;
  import cga_mac_pkg::*;

  logic        MCLK = 1'b0;
  logic        RESETN = 1'b1;
  logic        REQ = 1'b0;
  logic [5:0]  VA_15_10 = '0;
  logic        WR = 1'b0;
  logic        FETCH = 1'b0;
  logic [15:0] PCR_15_7_2_0 = '0;
  logic        PEX = 1'b0;
  logic [1:0]  XPT_1_0 = '0;
  logic        INVAL = 1'b0;
  logic        PTRD;
  logic [7:0]  PTADR;
  logic        PTACK = 1'b0;
  logic [15:0] PTDATA = '0;
  logic        BUSY;
  logic        DONE;
  logic        FAULT;
  logic [2:0]  FCODE;
  logic [8:0]  PPN;

  int compared = 0;
  int mismatched = 0;
  logic [12:0] exp_q[$];  // {fault, fcode, ppn}

  cga_mac_ptlook dut (
    .MCLK(MCLK), .RESETN(RESETN), .REQ(REQ), .VA_15_10(VA_15_10), .WR(WR),
    .FETCH(FETCH), .PCR_15_7_2_0(PCR_15_7_2_0), .PEX(PEX), .XPT_1_0(XPT_1_0),
    .INVAL(INVAL), .PTRD(PTRD), .PTADR(PTADR), .PTACK(PTACK), .PTDATA(PTDATA),
    .BUSY(BUSY), .DONE(DONE), .FAULT(FAULT), .FCODE(FCODE), .PPN(PPN)
  );

  // Clock / reset
  always #5 MCLK = ~MCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge MCLK) begin
    logic [12:0] e;
    if (RESETN && DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {19'd0, FAULT, FCODE, PPN}, {19'd0, e});
      end
    end
  end

  // Driver: issue one request and follow it to DONE.
  // ack_at: negedge index (1 = first LOOK cycle) at which PTACK is raised;
  // 0 = never. PTACK then stays high with inverted data to show it is
  // ignored outside LOOK.
  task automatic lookup(input logic [5:0] page, input logic wr, input logic fetch,
                        input logic [15:0] pcr, input logic pex, input logic [1:0] xpt,
                        input int ack_at, input logic [15:0] data,
                        input logic [7:0] exp_adr, input logic hit, input int exp_lat,
                        input logic [2:0] exp_fc, input logic [8:0] exp_ppn,
                        input int exp_rd);
    int n;
    int rd_cyc;
    logic seen;
    @(negedge MCLK);
    VA_15_10 = page; WR = wr; FETCH = fetch;
    PCR_15_7_2_0 = pcr; PEX = pex; XPT_1_0 = xpt; REQ = 1'b1;
    exp_q.push_back({exp_fc != 3'd0, exp_fc, (exp_fc != 3'd0) ? 9'h000 : exp_ppn});
    @(negedge MCLK);
    REQ = 1'b0;
    // Scramble the request inputs: the translation must use latched values.
    PCR_15_7_2_0 = 16'($urandom);
    PEX = 1'($urandom);
    XPT_1_0 = 2'($urandom);
    VA_15_10 = 6'($urandom);
    WR = 1'($urandom);
    FETCH = 1'($urandom);
    chk("busy", {31'd0, BUSY}, 32'd1);
    chk("ptrd_start", {31'd0, PTRD}, {31'd0, !hit});
    n = 1; rd_cyc = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      if (PTRD) begin
        rd_cyc++;
        chk("ptadr", {24'd0, PTADR}, {24'd0, exp_adr});
      end
      PTACK  = (ack_at > 0) && (n >= ack_at);
      PTDATA = (n == ack_at) ? data : ~data;
      @(negedge MCLK);
      n++;
      seen = DONE;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", n, exp_lat);
    chk("ptrd_cycles", rd_cyc, exp_rd);
    @(negedge MCLK);
    PTACK = 1'b0;
    chk("done_pulse", {31'd0, DONE}, 32'd0);
    chk("idle", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #2 RESETN = 1'b0;
    repeat (2) @(negedge MCLK);
    chk("rst_ptrd", {31'd0, PTRD}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_result", {19'd0, FAULT, FCODE, PPN}, 32'd0);
    chk("rst_ptadr", {24'd0, PTADR}, 32'd0);
    RESETN = 1'b1;

    // Read hit: pt 2, page 05 -> PPN 123
    lookup(6'h05, 1'b0, 1'b0, 16'h0100, 1'b0, 2'd0, 1, 16'h4123, 8'h85, 1'b0, 4, FC_NONE, 9'h123, 1);
    // Alternative table, write without WPM
    lookup(6'h2A, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd3, 1, 16'h4077, 8'hEA, 1'b0, 4, FC_WR, 9'h000, 1);
    // Ring violation, then not-present takes priority
    lookup(6'h11, 1'b0, 1'b0, 16'h0081, 1'b0, 2'd0, 1, 16'hE411, 8'h51, 1'b0, 4, FC_RING, 9'h000, 1);
    lookup(6'h11, 1'b0, 1'b0, 16'h0081, 1'b0, 2'd0, 1, 16'h0000, 8'h51, 1'b0, 4, FC_NP, 9'h000, 1);
    // Fetch without FPM, late ack
    lookup(6'h3F, 1'b0, 1'b1, 16'h0180, 1'b0, 2'd0, 3, 16'hC055, 8'hFF, 1'b0, 6, FC_FETCH, 9'h000, 3);
    // Read without RPM
    lookup(6'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 1, 16'h8055, 8'h00, 1'b0, 4, FC_RD, 9'h000, 1);
    // Ring equal to entry ring passes; XPT ignored when PEX=0
    lookup(6'h0C, 1'b0, 1'b0, 16'h0003, 1'b0, 2'd2, 2, 16'h47FF, 8'h0C, 1'b0, 5, FC_NONE, 9'h1FF, 2);
    // Permitted write
    lookup(6'h01, 1'b1, 1'b0, 16'h0100, 1'b0, 2'd0, 1, 16'h80A5, 8'h81, 1'b0, 4, FC_NONE, 9'h0A5, 1);
    // Timeout: PTRD for 15 cycles
    lookup(6'h07, 1'b0, 1'b0, 16'h0080, 1'b0, 2'd0, 0, 16'h4123, 8'h47, 1'b0, 17, FC_TMO, 9'h000, 15);

    // Reset mid-LOOK
    @(negedge MCLK);
    VA_15_10 = 6'h09; PCR_15_7_2_0 = 16'h0100; PEX = 1'b0; WR = 1'b0; FETCH = 1'b0; REQ = 1'b1;
    @(negedge MCLK);
    REQ = 1'b0;
    chk("look_ptrd", {31'd0, PTRD}, 32'd1);
    #2 RESETN = 1'b0;
    #1;
    chk("async_ptrd", {31'd0, PTRD}, 32'd0);
    chk("async_busy", {31'd0, BUSY}, 32'd0);
    chk("async_done", {31'd0, DONE}, 32'd0);
    @(negedge MCLK);
    RESETN = 1'b1;
    lookup(6'h05, 1'b0, 1'b0, 16'h0100, 1'b0, 2'd0, 1, 16'h4123, 8'h85, 1'b0, 4, FC_NONE, 9'h123, 1);

`ifdef CGA_MAC_PTCACHE_EN
    // Cached: no PTRD, DONE one cycle earlier
    lookup(6'h05, 1'b0, 1'b0, 16'h0100, 1'b0, 2'd0, 0, 16'h0000, 8'h85, 1'b1, 3, FC_NONE, 9'h123, 0);
    // Cached entry still checked against the current access: write faults
    lookup(6'h05, 1'b1, 1'b0, 16'h0100, 1'b0, 2'd0, 0, 16'h0000, 8'h85, 1'b1, 3, FC_WR, 9'h000, 0);
    @(negedge MCLK); INVAL = 1'b1;
    @(negedge MCLK); INVAL = 1'b0;
    lookup(6'h05, 1'b0, 1'b0, 16'h0100, 1'b0, 2'd0, 1, 16'h4123, 8'h85, 1'b0, 4, FC_NONE, 9'h123, 1);
`endif

    repeat (3) @(negedge MCLK);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
